// File: rtl/uart_reg_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_reg_bridge: parses W/R register frames from the UART RX FIFO, drives  |
// | an 8-bit register bus and returns one response byte per frame.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_reg_bridge #(
  parameter logic [7:0] OP_WR    = 8'h57,
  parameter logic [7:0] OP_RD    = 8'h52,
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter logic [7:0] NAK_BYTE = 8'h3F,
  parameter int         TIMEOUT  = 50_000,
  parameter int         TO_BIT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_wr,
  output logic       bus_rd,
  input  logic [7:0] bus_rdata,
  output logic       busy,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    BUS_WR   = 3'd3,
    BUS_RD   = 3'd4,
    RD_WAIT  = 3'd5,
    SEND     = 3'd6
  } state_t;

  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [TO_BIT-1:0] to_cnt, to_cnt_nxt;
  logic              wr_flag, wr_flag_nxt;
  logic [7:0]        addr_nxt, wdata_nxt, tx_nxt;
  logic              err_nxt;
  logic              consume;

  // Strobes are decoded straight from the registered state so they never glitch.
  assign consume = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
  assign rd_uart = consume & ~rx_empty & ~reset;
  assign wr_uart = (state == SEND) & ~tx_full & ~reset;
  assign bus_wr  = (state == BUS_WR);
  assign bus_rd  = (state == BUS_RD);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    wr_flag_nxt = wr_flag;
    addr_nxt    = bus_addr;
    wdata_nxt   = bus_wdata;
    tx_nxt      = w_data;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        to_cnt_nxt = '0;
        if (!rx_empty) begin
          if (r_data == OP_WR) begin
            wr_flag_nxt = 1'b1;
            state_nxt   = GET_ADDR;
          end else if (r_data == OP_RD) begin
            wr_flag_nxt = 1'b0;
            state_nxt   = GET_ADDR;
          end else begin
            tx_nxt    = NAK_BYTE;
            err_nxt   = 1'b1;
            state_nxt = SEND;
          end
        end
      end
      GET_ADDR, GET_DATA: begin
        if (!rx_empty) begin
          to_cnt_nxt = '0;
          if (state == GET_ADDR) begin
            addr_nxt  = r_data;
            state_nxt = wr_flag ? GET_DATA : BUS_RD;
          end else begin
            wdata_nxt = r_data;
            state_nxt = BUS_WR;
          end
        end else if (to_cnt == TO_LAST) begin
          // Abandon the frame; partial address/data updates are kept on purpose.
          tx_nxt    = NAK_BYTE;
          err_nxt   = 1'b1;
          state_nxt = SEND;
        end else begin
          to_cnt_nxt = to_cnt + TO_BIT'(1);
        end
      end
      BUS_WR: begin
        tx_nxt    = ACK_BYTE;
        state_nxt = SEND;
      end
      BUS_RD:  state_nxt = RD_WAIT;
      RD_WAIT: begin
        tx_nxt    = bus_rdata;
        state_nxt = SEND;
      end
      SEND:    if (!tx_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      to_cnt    <= '0;
      wr_flag   <= 1'b0;
      bus_addr  <= 8'h00;
      bus_wdata <= 8'h00;
      w_data    <= 8'h00;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      to_cnt    <= to_cnt_nxt;
      wr_flag   <= wr_flag_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
      w_data    <= tx_nxt;
      cmd_err   <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_reg_bridge: scoreboard bench with RX FIFO, register slave and TX   |
// | backpressure models around uart_reg_bridge.  Rev 1.0                       |
// +----------------------------------------------------------------------------+
module tb_uart_reg_bridge;

  localparam int         TIMEOUT = 20;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] ACK     = 8'h4B;
  localparam logic [7:0] NAK     = 8'h3F;
  localparam int         DEPTH   = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic       tx_full = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic [7:0] bus_rdata = 8'h00;
  logic       rd_uart, wr_uart, bus_wr, bus_rd, busy, cmd_err;
  logic [7:0] w_data, bus_addr, bus_wdata;

  uart_reg_bridge #(
    .OP_WR(OP_WR), .OP_RD(OP_RD), .ACK_BYTE(ACK), .NAK_BYTE(NAK),
    .TIMEOUT(TIMEOUT), .TO_BIT(5)
  ) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RX FIFO contents (stimulus writes, FIFO model reads)
  logic [7:0] rx_mem [DEPTH];
  int         rx_wp = 0, rx_rp = 0;

  // Expected responses: byte, error flag, cycles from final pop to first SEND cycle
  logic [7:0] rs_byte [DEPTH];
  bit         rs_err  [DEPTH];
  int         rs_lat  [DEPTH];
  int         rs_wp = 0, rs_rp = 0;

  // Expected bus operations
  bit         bo_wr   [DEPTH];
  logic [7:0] bo_addr [DEPTH];
  logic [7:0] bo_data [DEPTH];
  int         bo_wp = 0, bo_rp = 0;

  int nchk = 0, nerr = 0;
  bit done = 1'b0;

  // FIFO + register slave: read data valid only in the cycle after bus_rd
  logic [7:0] smem [256];
  initial begin
    bit s_pop, s_rd, s_wr;
    logic [7:0] s_addr, s_wd;
    for (int i = 0; i < 256; i++) smem[i] = 8'(i) ^ 8'h2C;
    forever begin
      @(negedge clk);
      s_pop = rd_uart; s_rd = bus_rd; s_wr = bus_wr; s_addr = bus_addr; s_wd = bus_wdata;
      @(posedge clk);
      #2;
      if (s_pop) rx_rp++;
      if (s_wr) smem[s_addr] = s_wd;
      bus_rdata = s_rd ? smem[s_addr] : 8'($urandom);
      rx_empty  = (rx_rp == rx_wp);
      r_data    = rx_mem[rx_rp % DEPTH];
    end
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard checker
  initial begin
    bit prev_rst, err_seen;
    int last_pop, full_start, full_last, nstb, exp_send, k;
    prev_rst = 1'b0; err_seen = 1'b0;
    last_pop = 0; full_start = 0; full_last = -10;
    forever begin
      @(negedge clk);
      if (done) break;
      nstb = int'(rd_uart) + int'(wr_uart) + int'(bus_wr) + int'(bus_rd);
      if (nstb > 0) chk(nstb == 1, "one_strobe", nstb, 1);
      if (reset) begin
        chk(!rd_uart && !wr_uart, "rst_no_pop_push", {rd_uart, wr_uart}, 0);
        err_seen = 1'b0;
      end
      if (prev_rst)
        chk({busy, bus_wr, bus_rd, cmd_err, bus_addr, bus_wdata, w_data} == 28'd0,
            "reset_outputs", {busy, bus_wr, bus_rd, cmd_err, bus_addr, bus_wdata, w_data}, 0);
      if (!reset) begin
        if (rd_uart) last_pop = cyc;
        if (cmd_err) err_seen = 1'b1;
        if (bus_wr || bus_rd) begin
          if (bo_rp == bo_wp) chk(1'b0, "bus_unexpected", {bus_wr, bus_addr}, 0);
          else begin
            k = bo_rp % DEPTH;
            chk(bo_wr[k] == bus_wr && bus_addr == bo_addr[k] && (!bus_wr || bus_wdata == bo_data[k]),
                "bus_op", {bus_wr, bus_addr, bus_wdata}, {bo_wr[k], bo_addr[k], bo_data[k]});
            chk(cyc == last_pop + 1, "bus_latency", cyc - last_pop, 1);
            bo_rp++;
          end
        end
        if (wr_uart) begin
          if (rs_rp == rs_wp) chk(1'b0, "push_unexpected", w_data, 0);
          else begin
            k = rs_rp % DEPTH;
            chk(w_data == rs_byte[k], "resp_byte", w_data, rs_byte[k]);
            chk(err_seen == rs_err[k], "cmd_err", err_seen, rs_err[k]);
            chk(busy && !tx_full, "push_busy_notfull", {busy, tx_full}, 2);
            // A later push is only legal if tx_full covered every cycle since SEND began
            exp_send = last_pop + rs_lat[k];
            chk(cyc == exp_send || (cyc > exp_send && full_start <= exp_send && full_last == cyc - 1),
                "push_latency", cyc - last_pop, rs_lat[k]);
            rs_rp++;
          end
          err_seen = 1'b0;
        end
      end
      if (tx_full) begin
        if (full_last != cyc - 1) full_start = cyc;
        full_last = cyc;
      end
      prev_rst = reset;
    end
    chk(rs_rp == rs_wp, "resp_drained", rs_wp - rs_rp, 0);
    chk(bo_rp == bo_wp, "bus_drained", bo_wp - bo_rp, 0);
    chk(rx_rp == rx_wp, "rx_drained", rx_wp - rx_rp, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  // Stimulus and reference model
  logic [7:0] mem_ref [256];
  bit rand_bp = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) tx_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic put(input logic [7:0] b);
    rx_mem[rx_wp % DEPTH] = b;
    rx_wp++;
  endtask

  task automatic exp_resp(input logic [7:0] b, input bit e, input int lat);
    rs_byte[rs_wp % DEPTH] = b; rs_err[rs_wp % DEPTH] = e; rs_lat[rs_wp % DEPTH] = lat;
    rs_wp++;
  endtask

  task automatic exp_bus(input bit w, input logic [7:0] a, input logic [7:0] d);
    bo_wr[bo_wp % DEPTH] = w; bo_addr[bo_wp % DEPTH] = a; bo_data[bo_wp % DEPTH] = d;
    bo_wp++;
  endtask

  task automatic frame_wr(input logic [7:0] a, input logic [7:0] d, input int gap);
    exp_bus(1'b1, a, d);
    exp_resp(ACK, 1'b0, 2);
    mem_ref[a] = d;
    put(OP_WR); repeat (gap) tick();
    put(a);     repeat (gap) tick();
    put(d);
  endtask

  task automatic frame_rd(input logic [7:0] a, input int gap);
    exp_bus(1'b0, a, 8'h00);
    exp_resp(mem_ref[a], 1'b0, 3);
    put(OP_RD); repeat (gap) tick();
    put(a);
  endtask

  task automatic frame_bad(input logic [7:0] b);
    exp_resp(NAK, 1'b1, 1);
    put(b);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rs_rp != rs_wp || rx_rp != rx_wp) && n < budget) begin
      tick();
      n++;
    end
    repeat (2) tick();
  endtask

  initial begin
    int n, kind;
    logic [7:0] a, d, b;
    for (int i = 0; i < 256; i++) mem_ref[i] = 8'(i) ^ 8'h2C;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    frame_wr(8'h05, 8'hA5, 0);
    drain(200);
    frame_rd(8'h10, 0);          // slave returns 3C here
    drain(200);
    frame_bad(8'h41);
    frame_rd(8'h00, 1);
    drain(200);

    // Timeout: address arrives, data never does
    exp_resp(NAK, 1'b1, TIMEOUT + 1);
    put(OP_WR); tick(); put(8'h07);
    drain(200);

    // Backpressure across a read response
    tx_full = 1'b1;
    frame_rd(8'h20, 0);
    repeat (100) tick();
    tx_full = 1'b0;
    drain(200);

    // Reset in the middle of a write frame, next byte is a fresh opcode
    put(OP_WR); put(8'h01);
    n = 0;
    while (rx_rp != rx_wp && n < 50) begin tick(); n++; end
    tick();
    reset = 1'b1;
    exp_bus(1'b0, 8'h10, 8'h00);
    exp_resp(mem_ref[8'h10], 1'b0, 3);
    put(OP_RD); put(8'h10);
    tick();
    reset = 1'b0;
    drain(200);

    // Randomised frames with random TX backpressure
    rand_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      kind = int'($urandom_range(0, 9));
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      if (kind < 4) frame_wr(a, d, int'($urandom_range(0, 3)));
      else if (kind < 8) frame_rd(a, int'($urandom_range(0, 3)));
      else begin
        b = 8'($urandom);
        if (b == OP_WR || b == OP_RD) b = 8'h00;
        frame_bad(b);
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_bp = 1'b0;
    tx_full = 1'b0;
    drain(3000);
    done = 1'b1;
  end

endmodule
`default_nettype wire
